// File: rtl/ysyx_24080014_pkg.sv
// Shared IFU definitions: FSM state encoding, reset PC and the NOP word.
// Also holds a small alignment helper used by the fetch unit.
package ysyx_24080014_pkg;

   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ      = 2'd0,
      S_WAIT     = 2'd1,
      S_DELIVER  = 2'd2,
      S_WAIT_NPC = 2'd3
   } ifu_state_e;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_24080014_counter.sv
// Free-running event counter with enable and sync reset; wraps at 2^WIDTH.
// Ports: clk, rst (sync, active-high), en (count this cycle), cnt (value).
module ysyx_24080014_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction per
// retirement over the imem valid/ready bus and hands {pc, inst, fault}
// to decode. Ports: clk/rst, npc_valid/next_pc from next-PC select,
// imem_req_*/imem_rsp_* memory bus, inst_* decode handshake, fetch_cnt.
module ysyx_24080014_ifu
   import ysyx_24080014_pkg::*;
#(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            npc_valid,
   input  logic [XLEN-1:0] next_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc,
   output logic            inst_fault,
   output logic [31:0]     fetch_cnt
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            fault_q, fault_d;

   logic aligned;
   logic req_fire;
   logic dlv_fire;

   assign aligned = is_aligned(pc_q[1:0]);

   // Request is suppressed during reset so the shared-reset memory
   // never sees a handshake that this unit is about to forget.
   assign imem_req_valid = (state_q == S_REQ) && aligned && !rst;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign dlv_fire       = (state_q == S_DELIVER) && inst_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      fault_d = fault_q;
      unique case (state_q)
         S_REQ: begin
            // A misaligned PC never reaches the bus; report it as a
            // faulting NOP so decode raises the exception.
            if (!aligned) begin
               state_d = S_DELIVER;
               inst_d  = XLEN'(NOP_INST);
               fault_d = 1'b1;
            end else if (req_fire) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_d = S_DELIVER;
               inst_d  = imem_rsp_data;
               fault_d = imem_rsp_err;
            end
         end
         S_DELIVER: begin
            if (inst_ready) begin
               if (npc_valid) begin
                  pc_d    = next_pc;
                  state_d = S_REQ;
               end else begin
                  state_d = S_WAIT_NPC;
               end
            end
         end
         S_WAIT_NPC: begin
            if (npc_valid) begin
               pc_d    = next_pc;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= XLEN'(NOP_INST);
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         fault_q <= fault_d;
      end
   end

   ysyx_24080014_counter #(
      .WIDTH(32)
   ) u_fetch_cnt (
      .clk (clk),
      .rst (rst),
      .en  (dlv_fire),
      .cnt (fetch_cnt)
   );

   assign imem_req_addr = pc_q;
   assign pc            = pc_q;
   assign inst          = inst_q;
   assign inst_fault    = fault_q;
   assign inst_valid    = (state_q == S_DELIVER);

endmodule

// File: doc/ysyx_24080014_ifu.md
Name: ysyx_24080014_ifu

Overview:
Instruction fetch unit: holds the architectural PC and fetches one instruction per retired instruction over a valid/ready instruction-memory bus. Delivers {pc, inst} to the decode stage through a valid/ready handshake. Loads the next PC from the next-PC selection stage when writeback signals retirement. Single-issue, one fetch outstanding, no prediction.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
XLEN, 32, address and instruction width.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
npc_valid  in  1  writeback has retired the current instruction; next_pc is valid this cycle.
next_pc  in  XLEN  PC of the next instruction, from next-PC selection.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts the request.
imem_req_addr  out  XLEN  fetch address; always equals pc.
imem_rsp_valid  in  1  fetch response valid.
imem_rsp_data  in  XLEN  fetched instruction word.
imem_rsp_err  in  1  bus error on this response.
inst_valid  out  1  instruction available to decode.
inst_ready  in  1  decode accepts the instruction.
inst  out  XLEN  instruction word, held stable while inst_valid=1.
pc  out  XLEN  address of inst, or the current fetch target.
inst_fault  out  1  instruction access or misalignment fault; qualified by inst_valid.
fetch_cnt  out  32  count of completed inst handshakes; wraps.

Behaviour:
- Reset values: pc=RESET_PC, state=REQ, imem_req_valid=0 during the reset cycle, inst_valid=0, inst=32'h0000_0013 (nop), inst_fault=0, fetch_cnt=0.
- FSM states: REQ, WAIT, DELIVER, WAIT_NPC.
- REQ: drive imem_req_valid=1 and addr=pc. If pc[1:0]!=0, do not issue; go to DELIVER with inst_fault=1, inst=nop. Otherwise, on req_valid&&req_ready go to WAIT. Request fields stay stable until accepted.
- WAIT: on imem_rsp_valid, register inst=rsp_data and inst_fault=rsp_err, then go to DELIVER. Response has minimum 1-cycle latency after acceptance.
- DELIVER: inst_valid=1. inst, pc and inst_fault stay stable until inst_valid&&inst_ready.
  - On the handshake, fetch_cnt increments by 1 (wraps at 2^32).
  - If npc_valid is also 1 in the handshake cycle, load pc=next_pc and go to REQ.
  - Otherwise go to WAIT_NPC.
- WAIT_NPC: inst_valid=0. When npc_valid=1, load pc=next_pc and go to REQ.
- Latency: a zero-wait memory gives REQ→WAIT→DELIVER, so inst_valid rises 2 cycles after the request is accepted.
- Ignored inputs:
  - npc_valid in REQ or WAIT is ignored, and pc is unchanged.
  - imem_rsp_valid outside WAIT is ignored; no state change.
- rst mid-operation: any outstanding fetch is abandoned (the memory shares rst). State returns to REQ, pc=RESET_PC, inst_valid drops on the next edge.
- next_pc bit 0 is not cleared here; a misaligned next_pc produces a fault per REQ.
- All arithmetic is unsigned, modulo 2^XLEN.

Decomposition:
- Shared package ysyx_24080014_pkg: IFU state encoding (2-bit enum REQ/WAIT/DELIVER/WAIT_NPC), RESET_PC, NOP_INST=32'h0000_0013.
- The FSM plus PC register fits in one module.
- The fetch counter is a natural sub-module ysyx_24080014_counter (width param, enable, sync reset), reusable for perf counters.

Test Plan:
1. Zero-wait memory returns 32'h00100093 for addr 8000_0000; inst_ready=1; npc_valid=1 with next_pc=8000_0004 at the handshake → inst_valid 2 cycles after acceptance, pc=8000_0000, next request addr=8000_0004, fetch_cnt=1.
2. Back-pressure: inst_ready=0 for 5 cycles → inst, pc and inst_fault stable; no new imem_req_valid; fetch_cnt unchanged until the handshake.
3. req_ready held low 3 cycles, then rsp_valid 4 cycles after acceptance → addr stable throughout; exactly one request accepted; inst captured correctly.
4. Misaligned path: next_pc=8000_0002 → no imem request; inst_valid=1 with inst_fault=1 and inst=32'h13; rsp_err=1 on a later aligned fetch → inst_fault=1.
5. Stale inputs: npc_valid pulse during WAIT and rsp_valid during WAIT_NPC → both ignored; pc unchanged; no extra inst_valid.
6. rst asserted in WAIT, then a late rsp_valid arrives → pc=8000_0000, state REQ; late response ignored; fetch_cnt=0; a fresh fetch is issued.
